// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory between the pipeline (cpu) and debug loader (dbg)
// ports; checks alignment/range and sequences a 1-cycle registered memory access.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates, latches command, checks legality
// ISSUE | memory strobe/address/data driven for exactly one cycle
// RESP  | ack (and err) to the owning port for one cycle
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [1:0]            dbg_size,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic                  dbg_err,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_mask_1,
  output logic                  mem_mask_2,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    last_dbg_q, last_dbg_d;
  logic                    owner_dbg_q, owner_dbg_d;
  logic                    err_flag_q, err_flag_d;
  logic [7:0]              err_count_q, err_count_d;
  logic                    mem_write_q, mem_write_d;
  logic                    mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]              mem_size_q, mem_size_d;

  logic                    sel_dbg;
  logic                    sel_we;
  logic [1:0]              sel_size;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    aligned;
  logic [ADDR_WIDTH:0]     byte_cnt;
  logic [ADDR_WIDTH:0]     end_addr;
  logic                    legal;

  // Winner selection and legality of the command about to be latched
  always_comb begin
    sel_dbg   = dbg_req & (~cpu_req | (~FIXED_PRIO & ~last_dbg_q));
    sel_we    = sel_dbg ? dbg_we    : cpu_we;
    sel_size  = sel_dbg ? dbg_size  : cpu_size;
    sel_addr  = sel_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = sel_dbg ? dbg_wdata : cpu_wdata;
    aligned   = 1'b1;
    byte_cnt  = (ADDR_WIDTH+1)'(1);
    case (sel_size)
      2'b00: begin aligned = (sel_addr[1:0] == 2'b00); byte_cnt = (ADDR_WIDTH+1)'(4); end
      2'b01: begin aligned = (sel_addr[1:0] == 2'b00); byte_cnt = (ADDR_WIDTH+1)'(3); end
      2'b10: begin aligned = ~sel_addr[0];             byte_cnt = (ADDR_WIDTH+1)'(2); end
      default: begin aligned = 1'b1;                   byte_cnt = (ADDR_WIDTH+1)'(1); end
    endcase
    end_addr = {1'b0, sel_addr} + byte_cnt;
    legal    = aligned & (end_addr <= (ADDR_WIDTH+1)'(MEM_SIZE));
  end

  always_comb begin
    state_d     = state_q;
    last_dbg_d  = last_dbg_q;
    owner_dbg_d = owner_dbg_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_size_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          owner_dbg_d = sel_dbg;
          last_dbg_d  = sel_dbg;
          err_flag_d  = ~legal;
          if (legal) begin
            mem_write_d = sel_we;
            mem_read_d  = ~sel_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_size_d  = sel_size;
            state_d     = ISSUE;
          end else begin
            state_d     = RESP;
          end
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (err_flag_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dbg_q  <= 1'b1;
      owner_dbg_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= 8'd0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_dbg_q  <= last_dbg_d;
      owner_dbg_q <= owner_dbg_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
    end
  end

  assign cpu_ack    = (state_q == RESP) & ~owner_dbg_q;
  assign dbg_ack    = (state_q == RESP) &  owner_dbg_q;
  assign cpu_err    = cpu_ack & err_flag_q;
  assign dbg_err    = dbg_ack & err_flag_q;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_ack;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mask_1 = mem_size_q[1];
  assign mem_mask_2 = mem_size_q[0];
  assign busy       = (state_q != IDLE);
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, random traffic against a byte-array
// reference model, arbitration, reset-in-flight and error-count saturation.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [1:0]  cpu_size, dbg_size;
  logic [5:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_write, mem_read, mem_mask_1, mem_mask_2, busy;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  err_count;

  logic        fp_cpu_ack, fp_cpu_err, fp_cpu_stall, fp_dbg_ack, fp_dbg_err;
  logic [31:0] fp_cpu_rdata, fp_dbg_rdata, fp_mem_wdata;
  logic        fp_mem_write, fp_mem_read, fp_mask_1, fp_mask_2, fp_busy;
  logic [5:0]  fp_mem_addr;
  logic [7:0]  fp_err_count;

  logic [7:0]  mem_b   [64] = '{default: 8'h00};
  logic [7:0]  ref_mem [64] = '{default: 8'h00};
  int          n_checks = 0;
  int          n_errs = 0;
  int          model_errs = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask_1(mem_mask_1), .mem_mask_2(mem_mask_2), .mem_rdata(mem_rdata),
    .busy(busy), .err_count(err_count)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(fp_cpu_ack), .cpu_err(fp_cpu_err), .cpu_rdata(fp_cpu_rdata),
    .cpu_stall(fp_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(fp_dbg_ack), .dbg_err(fp_dbg_err), .dbg_rdata(fp_dbg_rdata),
    .mem_write(fp_mem_write), .mem_read(fp_mem_read), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_mask_1(fp_mask_1), .mem_mask_2(fp_mask_2),
    .mem_rdata(mem_rdata), .busy(fp_busy), .err_count(fp_err_count)
  );

  // Little-endian byte memory: write on negedge, registered read on posedge
  function automatic logic [31:0] mem_fetch(input logic [5:0] a, input logic [1:0] sz);
    logic [31:0] r = '0;
    for (int i = 0; i < 4 - int'(sz); i++)
      if (int'(a) + i < 64) r[8*i +: 8] = mem_b[int'(a) + i];
    return r;
  endfunction

  always @(negedge clk)
    if (mem_write)
      for (int i = 0; i < 4 - int'({mem_mask_1, mem_mask_2}); i++)
        if (int'(mem_addr) + i < 64) mem_b[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];

  always @(posedge clk)
    if (mem_read) mem_rdata <= mem_fetch(mem_addr, {mem_mask_1, mem_mask_2});

  // Reference: byte count 4-size, alignment 4/4/2/1, must end within 64 bytes
  function automatic void model(input logic we, input logic [1:0] sz, input logic [5:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int n, al, ai;
    n  = 4 - int'(sz);
    al = (sz < 2) ? 4 : ((sz == 2) ? 2 : 1);
    ai = int'(a);
    err = ((ai % al) != 0) || (ai + n > 64);
    rd = '0;
    if (err) begin
      if (model_errs < 255) model_errs++;
    end else begin
      for (int i = 0; i < n; i++)
        if (we) ref_mem[ai + i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[ai + i];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction; starts just after a posedge with the DUT in IDLE.
  // lat counts cycles from the IDLE cycle that first sees req to the ack cycle.
  task automatic xact(input logic port, input logic we, input logic [1:0] sz,
                      input logic [5:0] a, input logic [31:0] wd,
                      output int lat, output logic err, output logic [31:0] rd,
                      output int mw, output int mr, output int st, output int oth);
    lat = -1; err = 1'b0; rd = '0; mw = 0; mr = 0; st = 0; oth = 0;
    if (!port) begin
      cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    end else begin
      dbg_we = we; dbg_size = sz; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mw  += int'(mem_write);
      mr  += int'(mem_read);
      st  += int'(cpu_stall);
      oth += int'(port ? cpu_ack : dbg_ack);
      if (port ? dbg_ack : cpu_ack) begin
        lat = k;
        err = port ? dbg_err : cpu_err;
        rd  = port ? dbg_rdata : cpu_rdata;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  sz;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [15];

  task automatic run_checked(input string tag, input logic port, input logic we,
                             input logic [1:0] sz, input logic [5:0] a, input logic [31:0] wd,
                             input logic e_err, input logic [31:0] e_rd);
    int lat, mw, mr, st, oth;
    logic err;
    logic [31:0] rd;
    xact(port, we, sz, a, wd, lat, err, rd, mw, mr, st, oth);
    chk({tag, " err"}, 32'(err), 32'(e_err));
    chk({tag, " latency"}, 32'(lat), e_err ? 32'd1 : 32'd2);
    if (!we && !e_err) chk({tag, " rdata"}, rd, e_rd);
    chk({tag, " mem_write cycles"}, 32'(mw), 32'(!e_err && we));
    chk({tag, " mem_read cycles"}, 32'(mr), 32'(!e_err && !we));
    if (!port) chk({tag, " stall cycles"}, 32'(st), e_err ? 32'd1 : 32'd2);
    chk({tag, " other ack"}, 32'(oth), 32'd0);
  endtask

  initial begin
    logic        m_err;
    logic [31:0] m_rd;
    logic [31:0] got;
    int          acc;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_size = 2'b00; dbg_addr = '0; dbg_wdata = '0;

    tbl[0]  = '{1'b0, 1'b1, 2'b00, 6'd8,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 2'b00, 6'd8,  32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 2'b11, 6'd9,  32'h0,        1'b0, 32'h000000BE};
    tbl[3]  = '{1'b1, 1'b0, 2'b10, 6'd8,  32'h0,        1'b0, 32'h0000BEEF};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 6'd6,  32'h0,        1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 2'b10, 6'd3,  32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 6'd61, 32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 2'b10, 6'd63, 32'h5555AAAA, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 6'd63, 32'h0,        1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 2'b11, 6'd15, 32'h000000AA, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 2'b01, 6'd12, 32'hFF112233, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 2'b00, 6'd12, 32'h0,        1'b0, 32'hAA112233};
    tbl[12] = '{1'b0, 1'b0, 2'b01, 6'd60, 32'h0,        1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 2'b00, 6'd60, 32'h01020304, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 2'b00, 6'd60, 32'h0,        1'b0, 32'h01020304};

    #13;
    chk("reset flags", 32'({busy, cpu_ack, dbg_ack, cpu_err, dbg_err, mem_write, mem_read,
                            cpu_stall, mem_mask_1, mem_mask_2}), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, m_err, m_rd);
      run_checked($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].sz, tbl[i].addr,
                  tbl[i].wd, tbl[i].e_err, tbl[i].e_rd);
    end
    chk("err_count after table", 32'(err_count), 32'd4);

    for (int i = 0; i < 80; i++) begin
      logic        p, w;
      logic [1:0]  s;
      logic [5:0]  a;
      logic [31:0] d;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      model(w, s, a, d, m_err, m_rd);
      run_checked($sformatf("rnd%0d", i), p, w, s, a, d, m_err, m_rd);
    end
    chk("err_count after random", 32'(err_count), 32'(model_errs));

    // Both ports hold read requests from reset: alternation vs fixed priority
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    model(1'b0, 2'b00, 6'd8, 32'h0, m_err, m_rd);
    cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 6'd8;  cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_size = 2'b00; dbg_addr = 6'd12; dbg_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [3:0] e;
      @(negedge clk);
      e = {(k == 2) || (k == 8), (k == 5) || (k == 11), (k % 3) == 2, 1'b0};
      chk($sformatf("arb acks c%0d (rr cpu,rr dbg,fp cpu,fp dbg)", k),
          32'({cpu_ack, dbg_ack, fp_cpu_ack, fp_dbg_ack}), 32'(e));
      if (k == 2) chk("arb cpu rdata", cpu_rdata, m_rd);
      if (k == 5) chk("arb cpu stall while dbg served", 32'(cpu_stall), 32'd1);
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Reset during ISSUE of a write abandons it without an ack
    cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 6'd20; cpu_wdata = 32'h12345678; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("issue mem_write before reset", 32'(mem_write), 32'd1);
    rst = 1'b1; #1;
    chk("mem_write after async reset", 32'(mem_write), 32'd0);
    chk("busy after async reset", 32'(busy), 32'd0);
    chk("err_count after async reset", 32'(err_count), 32'd0);
    cpu_req = 1'b0;
    #2; rst = 1'b0;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      acc += int'(cpu_ack) + int'(dbg_ack);
    end
    chk("no ack after abandoned access", 32'(acc), 32'd0);
    @(posedge clk); #1;
    run_checked("post-reset read", 1'b0, 1'b0, 2'b11, 6'd63, 32'h0, 1'b0, 32'(ref_mem[63]));

    for (int i = 0; i < 260; i++) begin
      int lat, mw, mr, st, oth;
      logic err;
      xact(1'b0, 1'b0, 2'b00, 6'd1, 32'h0, lat, err, got, mw, mr, st, oth);
      if (i == 254) chk("err_count at 255th error", 32'(err_count), 32'd255);
    end
    chk("err_count saturated", 32'(err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
